// File: rtl/alsu_pipe.sv
// Pipelined, handshaked ALSU: one-cycle logic/arith/shift ops plus a sequential signed shift-add multiplier.
// Results are widened to 2*WIDTH and announced with a single-cycle out_valid strobe.
module alsu_pipe #(
    parameter int WIDTH          = 8,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int LED_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic                   cin,
    input  logic                   serial_in,
    input  logic                   red_op_A,
    input  logic                   red_op_B,
    input  logic [2:0]             opcode,
    input  logic                   bypass_A,
    input  logic                   bypass_B,
    input  logic                   direction,
    output logic                   out_valid,
    output logic [2*WIDTH-1:0]     out,
    output logic                   err,
    output logic [LED_WIDTH-1:0]   leds
);

    localparam int OW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             serial_in;
        logic             red_a;
        logic             red_b;
        logic             byp_a;
        logic             byp_b;
        logic             dir;
        logic [2:0]       opcode;
    } req_t;

    state_t           state, next_state;
    req_t             s1;
    logic             s1_valid;

    logic [OW-1:0]    acc;
    logic [OW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             mul_neg;
    logic [CW-1:0]    cnt;

    logic             s1_bypass, s1_invalid, s1_mult;
    logic [WIDTH-1:0] byp_sel, red_sel, mag_a, mag_b;
    logic [OW-1:0]    sext_a, sext_b, sext_byp;
    logic [OW-1:0]    res_out;
    logic             res_err;
    logic [LED_WIDTH-1:0] res_leds;

    // Request decode: bypass beats everything, reduction is only legal on OR/XOR.
    assign s1_bypass  = s1.byp_a | s1.byp_b;
    assign s1_invalid = (s1.opcode > OP_ROTATE) ||
                        ((s1.red_a | s1.red_b) && (s1.opcode != OP_OR) && (s1.opcode != OP_XOR));
    assign s1_mult    = !s1_bypass && !s1_invalid && (s1.opcode == OP_MULT);

    // Ready drops on the edge a MULT is captured and returns once the product is written.
    assign in_ready = (state == IDLE) && !(s1_valid && s1_mult);

    assign byp_sel  = (s1.byp_a && (!s1.byp_b || PRIO_A)) ? s1.a : s1.b;
    assign red_sel  = (s1.red_a && (!s1.red_b || PRIO_A)) ? s1.a : s1.b;
    assign sext_a   = {{WIDTH{s1.a[WIDTH-1]}}, s1.a};
    assign sext_b   = {{WIDTH{s1.b[WIDTH-1]}}, s1.b};
    assign sext_byp = {{WIDTH{byp_sel[WIDTH-1]}}, byp_sel};
    assign mag_a    = s1.a[WIDTH-1] ? -s1.a : s1.a;
    assign mag_b    = s1.b[WIDTH-1] ? -s1.b : s1.b;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        res_out  = out;
        res_err  = 1'b0;
        res_leds = '0;
        if (s1_bypass) begin
            res_out = sext_byp;
        end else if (s1_invalid) begin
            res_out  = '0;
            res_err  = 1'b1;
            res_leds = ~leds;
        end else begin
            unique case (s1.opcode)
                OP_OR, OP_XOR: begin
                    if (s1.red_a | s1.red_b)
                        res_out = {{(OW-1){1'b0}}, (s1.opcode == OP_OR) ? |red_sel : ^red_sel};
                    else
                        res_out = (s1.opcode == OP_OR) ? (sext_a | sext_b) : (sext_a ^ sext_b);
                end
                OP_ADD:    res_out = sext_a + sext_b + OW'(s1.cin & USE_CIN);
                OP_SHIFT:  res_out = s1.dir ? {out[OW-2:0], s1.serial_in} : {s1.serial_in, out[OW-1:1]};
                OP_ROTATE: res_out = s1.dir ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
                default:   res_out = out;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (s1_valid && s1_mult) next_state = MUL_RUN;
            MUL_RUN:  if (cnt == CW'(WIDTH - 1)) next_state = MUL_DONE;
            MUL_DONE: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: all datapath registers are reset, so an abort mid-MULT leaves no stale product to strobe out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            leds      <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_neg   <= 1'b0;
            cnt       <= '0;
        end else begin
            s1_valid  <= in_valid && in_ready;
            out_valid <= 1'b0;
            if (in_valid && in_ready)
                s1 <= '{a: A, b: B, cin: cin, serial_in: serial_in, red_a: red_op_A, red_b: red_op_B,
                        byp_a: bypass_A, byp_b: bypass_B, dir: direction, opcode: opcode};

            unique case (state)
                IDLE: begin
                    if (s1_valid && s1_mult) begin
                        // First iteration happens on the load edge so the product lands WIDTH+1 edges after capture.
                        acc     <= mag_b[0] ? {{WIDTH{1'b0}}, mag_a} : '0;
                        mcand   <= {{WIDTH{1'b0}}, mag_a} << 1;
                        mplier  <= mag_b >> 1;
                        mul_neg <= s1.a[WIDTH-1] ^ s1.b[WIDTH-1];
                        cnt     <= CW'(1);
                    end else if (s1_valid) begin
                        out       <= res_out;
                        err       <= res_err;
                        leds      <= res_leds;
                        out_valid <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                MUL_DONE: begin
                    out       <= mul_neg ? -acc : acc;
                    err       <= 1'b0;
                    leds      <= '0;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
- Parametrised, handshaked successor to the 3-bit ALSU.
- Operand width is generic (WIDTH). Output is widened to 2*WIDTH so ADD and MULT never overflow.
- MULT is a sequential shift-add unit rather than a single-cycle multiplier.
- Sits between the operand register file and the result bus. Upstream uses a valid/ready handshake; downstream receives a one-cycle result strobe.

Parameters:
- WIDTH, 8, signed operand width in bits (>=2).
- INPUT_PRIORITY, "A", operand chosen when both bypass or both reduction flags are set ("A" or "B").
- FULL_ADDER, "ON", "ON" adds cin in ADD; "OFF" ignores cin.
- LED_WIDTH, 16, width of the error LED bus.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request; operands are sampled when in_valid && in_ready
- in_ready  out  1  block can accept a request
- A  in  WIDTH  signed operand A
- B  in  WIDTH  signed operand B
- cin  in  1  carry-in
- serial_in  in  1  SHIFT fill bit
- red_op_A  in  1  reduce A (OR/XOR only)
- red_op_B  in  1  reduce B (OR/XOR only)
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 INVALID
- bypass_A  in  1  pass A through
- bypass_B  in  1  pass B through
- direction  in  1  1 = left, 0 = right (SHIFT/ROTATE)
- out_valid  out  1  one-cycle strobe; out/err are updated on this edge
- out  out  2*WIDTH  signed result register; holds its value between strobes
- err  out  1  set with out_valid when the transaction was invalid; cleared by the next valid transaction
- leds  out  LED_WIDTH  error indicator

Behaviour:
- Reset (async, any state including mid-MULT):
  - in_ready=1, out_valid=0, out=0, err=0, leds=0, FSM=IDLE.
  - A pending MULT is discarded.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
- Capture: at edge N with in_valid && in_ready, all inputs are registered (stage 1).
- Non-MULT operations (stage 2):
  - Result written at edge N+1 with out_valid=1 for exactly one cycle.
  - in_ready stays 1, so one transaction per cycle is sustained back-to-back.
- Bypass: evaluated first and overrides opcode, invalidity and reduction.
  - Both bypass flags set: operand selected by INPUT_PRIORITY.
  - out = sign-extended operand; leds=0; err=0.
- Invalid transaction: opcode 6/7, or (red_op_A|red_op_B) with an opcode other than OR/XOR.
  - out=0, err=1, leds=~leds (toggle per invalid transaction).
  - Any valid transaction sets leds=0.
- OR/XOR:
  - Reduction flag set: result = |op or ^op, zero-extended to 0/1.
  - Both reduction flags set: operand selected by INPUT_PRIORITY.
  - Otherwise: bitwise op on sign-extended operands.
- ADD: sext(A)+sext(B)+(FULL_ADDER=="ON" ? cin : 0), computed at 2*WIDTH.
- SHIFT: operates on the current out register.
  - left: {out[2W-2:0], serial_in}
  - right: {serial_in, out[2W-1:1]}
- ROTATE: operates on the current out register.
  - left: {out[2W-2:0], out[2W-1]}
  - right: {out[0], out[2W-1:1]}
- SHIFT/ROTATE back-to-back: each transaction uses the out value written by the previous one, in acceptance order.
- MULT:
  - Capture edge N sets in_ready=0.
  - FSM moves IDLE->MUL_RUN at N+1 and runs WIDTH iterations of signed shift-add (magnitude multiply plus sign correction).
  - MUL_RUN->MUL_DONE after WIDTH iterations.
  - At edge N+WIDTH+1: out = exact signed product, out_valid=1, in_ready=1, FSM->IDLE.
  - Earliest next capture is edge N+WIDTH+2.
  - in_valid is ignored while in_ready=0.
  - A non-MULT transaction captured at N-1 completes normally at N before MULT starts.
- Boundary cases:
  - Most negative operands (-2^(W-1) * -2^(W-1)) give +2^(2W-2) with no overflow.
  - out_valid is never asserted two cycles for the same transaction.

Test Plan:
- WIDTH=8, ADD A=100 B=100 cin=1 FULL_ADDER="ON": captured edge N -> out=201, out_valid high only at N+1, err=0.
- MULT A=-128 B=-128: in_ready low N+1..N+8 -> out=16384 with out_valid at N+9; in_valid pulses during busy are ignored.
- opcode=6 twice back-to-back, then OR A=1 B=2: leds=FFFF, err=1 -> leds=0000, err=1 -> out=3, leds=0000, err=0.
- XOR with red_op_A=red_op_B=1, A=8'h07, B=8'h01, INPUT_PRIORITY="A": out=1. Same request with opcode=ADD: out=0, err=1.
- After ADD result out=16'h00C9: SHIFT dir=1 serial_in=1 -> 16'h0193; then ROTATE dir=0 -> 16'h80C9.
- rst asserted mid-MULT (MUL_RUN): out=0, in_ready=1, out_valid=0 immediately, with no late strobe. Next ADD A=1 B=1 cin=0 -> out=2 one cycle after capture.
